// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with flags, occupancy count and sticky errors.
// Latency: standard mode 1 cycle from rd to dout; FWFT mode head word visible the cycle after it is written.
// Backpressure: writes refused when full unless a read is accepted in the same cycle.
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   flush         synchronous clear of contents/pointers/count; error flags kept
//   wr, din       write request and data
//   rd            read request (FWFT: acknowledge of the word on dout)
//   dout          read data
//   dout_valid    dout holds a valid word
//   empty, full   count == 0 / count == DEPTH
//   almost_empty  count <= AE_LEVEL
//   almost_full   count >= AF_LEVEL
//   count         occupancy 0..DEPTH
//   overflow      sticky: write refused because full
//   underflow     sticky: read attempted while empty
//   clr_err       synchronous clear of overflow/underflow
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             rd_ok;
  logic             wr_ok;
  logic             set_ovf;
  logic             set_udf;

  // Status flags come straight from the registered count.
  assign count        = cnt;
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign almost_empty = (cnt <= AE_C);
  assign almost_full  = (cnt >= AF_C);

  // Read is resolved first so a simultaneous read frees a slot for the write
  // even when full. Flush masks both requests.
  assign rd_ok = rd & ~empty & ~flush;
  assign wr_ok = wr & (~full | rd_ok) & ~flush;

  // Requests swallowed by flush are not errors.
  assign set_ovf = wr & ~wr_ok & ~flush;
  assign set_udf = rd & empty & ~flush;

  // Storage is deliberately left unreset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A new error in the same cycle as clr_err wins, so the flag stays set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= set_ovf | (overflow  & ~clr_err);
      underflow <= set_udf | (underflow & ~clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is presented directly; gated to zero while empty so the
      // output is defined after reset even though memory is not.
      assign dout       = empty ? '0 : mem[rd_ptr];
      assign dout_valid = ~empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             dout_valid_q;

      // dout holds the last word read; flush only drops the valid strobe.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          dout_valid_q <= rd_ok;
          if (rd_ok) begin
            dout_q <= mem[rd_ptr];
          end
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
    end
  endgenerate

endmodule
